// File: rtl/spi_regfile_pkg.sv
// rtl/spi_regfile_pkg.sv - shared types and constants for the SPI register file
// Contents: FSM state enum, R/W bit encodings, frame width helper.
package spi_regfile_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  localparam logic SPI_RW_WRITE = 1'b1;
  localparam logic SPI_RW_READ  = 1'b0;

  // Frame = R/W bit + address field + data field, MSB first.
  function automatic int frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - two-flop synchroniser for one asynchronous input
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset, flops load RST_VAL
//   d_i   in  asynchronous input
//   q_o   out synchronised output
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_regfile.sv
// rtl/spi_regfile.sv - SPI mode-0 slave exposing NUM_REGS x DATA_W control registers
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   sclk, sdi   SPI clock and data in (asynchronous, synchronised here)
//   cs          SPI chip select, active low (asynchronous)
//   sdo         SPI read data out, 0 when not reading
//   regs_o      packed registers, reg k at [k*DATA_W +: DATA_W]
//   wr_pulse    one-clk strobe when a register is written
//   wr_addr     address of the last write
module spi_regfile
  import spi_regfile_pkg::*;
#(
  parameter int NUM_REGS = 5,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sclk,
  input  logic                         sdi,
  input  logic                         cs,
  output logic                         sdo,
  output logic [NUM_REGS*DATA_W-1:0]   regs_o,
  output logic                         wr_pulse,
  output logic [ADDR_W-1:0]            wr_addr
);

  localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam int BIT_W   = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_RD   = CNT_W'(1 + ADDR_W);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

  logic sclk_s, sdi_s, cs_s;
  logic sclk_d_q;
  logic sclk_rise, sclk_fall;

  state_e               state_q, state_d;
  logic [FRAME_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]    outreg_q, outreg_d;
  logic [BIT_W-1:0]     bits_q, bits_d;
  logic                 loaded_q, loaded_d;
  logic                 sdo_q, sdo_d;
  logic                 wr_pulse_q, wr_pulse_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;

  logic                 commit_wr;
  logic [ADDR_W-1:0]    commit_addr;
  logic [DATA_W-1:0]    commit_data;
  logic [ADDR_W-1:0]    lookup_addr;
  logic                 lookup_hit;
  logic [DATA_W-1:0]    lookup_data;

  spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d_i(sclk), .q_o(sclk_s));
  spi_sync #(.RST_VAL(1'b0)) u_sync_sdi  (.clk(clk), .rst_n(rst_n), .d_i(sdi),  .q_o(sdi_s));
  spi_sync #(.RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst_n(rst_n), .d_i(cs),   .q_o(cs_s));

  assign sclk_rise = sclk_s & ~sclk_d_q;
  assign sclk_fall = ~sclk_s & sclk_d_q;

  assign commit_addr = shreg_q[FRAME_W-2 -: ADDR_W];
  assign commit_data = shreg_q[DATA_W-1:0];

  // One register lookup serves both the read preload (address sits in the low
  // bits mid-frame) and the write decode (address field of the complete frame).
  always_comb begin
    lookup_addr = (state_q == COMMIT) ? commit_addr : shreg_q[ADDR_W-1:0];
    lookup_hit  = 1'b0;
    lookup_data = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (lookup_addr == ADDR_W'(k)) begin
        lookup_hit  = 1'b1;
        lookup_data = regs_o[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_d_q   <= 1'b0;
      state_q    <= IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      outreg_q   <= '0;
      bits_q     <= '0;
      loaded_q   <= 1'b0;
      sdo_q      <= 1'b0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
    end else begin
      sclk_d_q   <= sclk_s;
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      outreg_q   <= outreg_d;
      bits_q     <= bits_d;
      loaded_q   <= loaded_d;
      sdo_q      <= sdo_d;
      wr_pulse_q <= wr_pulse_d;
      wr_addr_q  <= wr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    outreg_d   = outreg_q;
    bits_d     = bits_q;
    loaded_d   = loaded_q;
    sdo_d      = sdo_q;
    wr_pulse_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    commit_wr  = 1'b0;
    case (state_q)
      IDLE: begin
        shreg_d  = '0;
        cnt_d    = '0;
        outreg_d = '0;
        bits_d   = '0;
        loaded_d = 1'b0;
        sdo_d    = 1'b0;
        if (!cs_s) state_d = SHIFT;
      end
      SHIFT: begin
        // cs rising wins over any sclk edge seen in the same cycle.
        if (cs_s) begin
          state_d = COMMIT;
        end else begin
          if (sclk_rise) begin
            shreg_d = {shreg_q[FRAME_W-2:0], sdi_s};
            if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
          end
          // Header complete: preload read data once; the 8x clock ratio
          // guarantees this lands before the next sclk fall.
          if (cnt_q == CNT_RD && !loaded_q) begin
            loaded_d = 1'b1;
            if (shreg_q[ADDR_W] == SPI_RW_READ) begin
              outreg_d = lookup_data;
              bits_d   = BIT_W'(DATA_W);
            end
          end
          if (sclk_fall) begin
            if (bits_q != '0) begin
              sdo_d    = outreg_q[DATA_W-1];
              outreg_d = outreg_q << 1;
              bits_d   = bits_q - BIT_W'(1);
            end else begin
              sdo_d = 1'b0;
            end
          end
        end
      end
      COMMIT: begin
        if (cnt_q == CNT_FULL && shreg_q[FRAME_W-1] == SPI_RW_WRITE && lookup_hit) begin
          commit_wr  = 1'b1;
          wr_pulse_d = 1'b1;
          wr_addr_d  = commit_addr;
        end
        shreg_d  = '0;
        cnt_d    = '0;
        outreg_d = '0;
        bits_d   = '0;
        loaded_d = 1'b0;
        sdo_d    = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
    logic [DATA_W-1:0] val_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) val_q <= '0;
      else if (commit_wr && commit_addr == ADDR_W'(k)) val_q <= commit_data;
    end
    assign regs_o[k*DATA_W +: DATA_W] = val_q;
  end

  assign sdo      = sdo_q;
  assign wr_pulse = wr_pulse_q;
  assign wr_addr  = wr_addr_q;

endmodule

// File: tb/tb_spi_regfile.sv
// tb/tb_spi_regfile.sv - self-checking bench for spi_regfile (default and 8x16/3-bit configs)
module tb_spi_regfile;

  localparam int H = 6;  // sclk half period in clk cycles

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   sclk_v, sdi_v, cs_v;
  wire  [1:0]   sdo_v, wrp_v;
  wire  [39:0]  regs0;
  wire  [127:0] regs1;
  wire  [6:0]   wra0;
  wire  [2:0]   wra1;

  logic [15:0]  mreg [2][8];
  int           pulse_cnt [2];
  logic [6:0]   last_addr [2];
  logic         prev_p [2];
  bit           chk_en;
  int           n_tests = 0;
  int           n_fail  = 0;

  spi_regfile u_dut0 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk_v[0]), .sdi(sdi_v[0]), .cs(cs_v[0]),
    .sdo(sdo_v[0]), .regs_o(regs0), .wr_pulse(wrp_v[0]), .wr_addr(wra0)
  );

  spi_regfile #(.NUM_REGS(8), .DATA_W(16), .ADDR_W(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk_v[1]), .sdi(sdi_v[1]), .cs(cs_v[1]),
    .sdo(sdo_v[1]), .regs_o(regs1), .wr_pulse(wrp_v[1]), .wr_addr(wra1)
  );

  always #5 clk = ~clk;

  function automatic int aw_of(input int d); return (d != 0) ? 3 : 7; endfunction
  function automatic int dw_of(input int d); return (d != 0) ? 16 : 8; endfunction
  function automatic int nr_of(input int d); return (d != 0) ? 8 : 5; endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Registers follow the model whenever no commit is in flight; wr_pulse
  // events are counted for the frame driver to reconcile.
  always @(negedge clk) begin
    logic [39:0]  e0;
    logic [127:0] e1;
    if (chk_en) begin
      for (int k = 0; k < 5; k++) e0[k*8 +: 8] = mreg[0][k][7:0];
      for (int k = 0; k < 8; k++) e1[k*16 +: 16] = mreg[1][k];
      check("regs0", {88'd0, regs0}, {88'd0, e0});
      check("regs1", regs1, e1);
    end
    for (int d = 0; d < 2; d++) begin
      if (wrp_v[d]) begin
        pulse_cnt[d]++;
        last_addr[d] = (d != 0) ? {4'd0, wra1} : wra0;
        check("wr_pulse_width", {127'd0, prev_p[d]}, 128'd0);
      end
      prev_p[d] = wrp_v[d];
    end
  end

  task automatic run_frame(input int d, input logic rw, input int addr, input logic [15:0] data,
                           input int len, input int abort_at, output logic [31:0] rx);
    int          aw, dw, fw, p0, a_m;
    logic [31:0] w, exp_rx;
    logic [15:0] rd, dm;
    logic        b, e, valid;
    aw = aw_of(d); dw = dw_of(d); fw = 1 + aw + dw;
    a_m = addr % (1 << aw);
    dm  = data & 16'((32'd1 << dw) - 1);
    w   = (32'(rw) << (aw + dw)) | (32'(a_m) << dw) | 32'(dm);
    rd  = (a_m < nr_of(d)) ? mreg[d][a_m] : 16'd0;
    p0  = pulse_cnt[d];
    rx = '0; exp_rx = '0;
    cs_v[d] = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (i == abort_at) begin
        rst_n = 1'b0;
        for (int dd = 0; dd < 2; dd++) for (int k = 0; k < 8; k++) mreg[dd][k] = '0;
        cs_v[d] = 1'b1; sclk_v[d] = 1'b0; sdi_v[d] = 1'b0;
        tick(3);
        check("rst_sdo", {126'd0, sdo_v}, 128'd0);
        check("rst_wr_pulse", {126'd0, wrp_v}, 128'd0);
        check("rst_wr_addr0", {121'd0, wra0}, 128'd0);
        check("rst_wr_addr1", {125'd0, wra1}, 128'd0);
        rst_n = 1'b1;
        tick(4);
        return;
      end
      b = (i < fw) ? w[fw-1-i] : 1'($urandom);
      sdi_v[d] = b;
      tick(H);
      rx = {rx[30:0], sdo_v[d]};
      e  = (rw == 1'b0 && i >= 1 + aw && i <= aw + dw) ? rd[dw-1-(i-1-aw)] : 1'b0;
      exp_rx = {exp_rx[30:0], e};
      sclk_v[d] = 1'b1;
      tick(H);
      sclk_v[d] = 1'b0;
    end
    tick(H);
    chk_en = 1'b0;
    cs_v[d] = 1'b1;
    tick(8);
    valid = (len == fw) && rw && (a_m < nr_of(d));
    if (valid) mreg[d][a_m] = dm;
    chk_en = 1'b1;
    check("sdo_stream", {96'd0, rx}, {96'd0, exp_rx});
    check("wr_pulse_count", 128'(pulse_cnt[d] - p0), valid ? 128'd1 : 128'd0);
    if (valid) check("wr_addr", {121'd0, last_addr[d]}, 128'(a_m));
  endtask

  initial begin
    logic [31:0] rx;
    int d, aw, fw, r, len, addr;
    rst_n = 1'b0; sclk_v = '0; sdi_v = '0; cs_v = 2'b11; chk_en = 1'b0;
    for (int dd = 0; dd < 2; dd++) begin
      pulse_cnt[dd] = 0; last_addr[dd] = '0; prev_p[dd] = 1'b0;
      for (int k = 0; k < 8; k++) mreg[dd][k] = '0;
    end
    tick(3);
    check("reset_regs0", {88'd0, regs0}, 128'd0);
    check("reset_regs1", regs1, 128'd0);
    check("reset_sdo", {126'd0, sdo_v}, 128'd0);
    check("reset_wr_pulse", {126'd0, wrp_v}, 128'd0);
    check("reset_wr_addr", {121'd0, wra0}, 128'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick(4);

    run_frame(0, 1'b1, 1, 16'hA5, 16, -1, rx);
    check("lit_reg1_A5", {120'd0, regs0[15:8]}, 128'hA5);
    check("lit_regs0_after_A5", {88'd0, regs0}, 128'h00_0000_A500);
    check("lit_wr_addr1", {121'd0, wra0}, 128'd1);

    run_frame(0, 1'b0, 1, 16'h00, 16, -1, rx);
    check("lit_read_A5", {112'd0, rx[15:0]}, 128'h00A5);

    run_frame(0, 1'b1, 5, 16'hFF, 16, -1, rx);
    run_frame(0, 1'b0, 5, 16'h00, 16, -1, rx);
    check("lit_read_addr5", {112'd0, rx[15:0]}, 128'd0);

    run_frame(0, 1'b1, 2, 16'h33, 15, -1, rx);
    run_frame(0, 1'b1, 2, 16'h33, 17, -1, rx);
    check("lit_regs0_after_badlen", {88'd0, regs0}, 128'h00_0000_A500);

    run_frame(0, 1'b1, 3, 16'h77, 16, 9, rx);
    check("lit_regs0_after_abort", {88'd0, regs0}, 128'd0);
    run_frame(0, 1'b1, 3, 16'h77, 16, -1, rx);
    check("lit_reg3_77", {120'd0, regs0[31:24]}, 128'h77);

    run_frame(1, 1'b1, 7, 16'h1234, 20, -1, rx);
    check("lit_d1_reg7", {112'd0, regs1[127:112]}, 128'h1234);
    run_frame(1, 1'b0, 7, 16'h0000, 20, -1, rx);
    check("lit_d1_read7", {108'd0, rx[19:0]}, 128'h0_1234);

    for (int n = 0; n < 60; n++) begin
      d  = int'($urandom_range(0, 1));
      aw = aw_of(d);
      fw = 1 + aw + dw_of(d);
      addr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, (1 << aw) - 1))
                                         : int'($urandom_range(0, nr_of(d)));
      r = int'($urandom_range(0, 7));
      if (r == 0)      len = fw - 1;
      else if (r == 1) len = fw + 1;
      else if (r == 2) len = int'($urandom_range(1, fw));
      else             len = fw;
      run_frame(d, 1'($urandom), addr, 16'($urandom), len, -1, rx);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
